// File: rtl/ps2_keyboard_rx_pkg.sv
// ps2_keyboard_rx_pkg
//   Shared constants for the PS/2 keyboard receiver: prefix bytes, keypad
//   scan codes (set 2), receiver FSM state encoding and a parity helper.
package ps2_keyboard_rx_pkg;

   // Prefix bytes folded into per-key events by the decoder
   localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
   localparam logic [7:0] KP_EXTENDED     = 8'hE0;

   // Keypad scan codes consumed by the calculator logic
   localparam logic [7:0] KP_0     = 8'h70;
   localparam logic [7:0] KP_1     = 8'h69;
   localparam logic [7:0] KP_2     = 8'h72;
   localparam logic [7:0] KP_3     = 8'h7A;
   localparam logic [7:0] KP_4     = 8'h6B;
   localparam logic [7:0] KP_5     = 8'h73;
   localparam logic [7:0] KP_6     = 8'h74;
   localparam logic [7:0] KP_7     = 8'h6C;
   localparam logic [7:0] KP_8     = 8'h75;
   localparam logic [7:0] KP_9     = 8'h7D;
   localparam logic [7:0] KP_DOT   = 8'h71;
   localparam logic [7:0] KP_PLUS  = 8'h79;
   localparam logic [7:0] KP_MINUS = 8'h7B;
   localparam logic [7:0] KP_STAR  = 8'h7C;
   localparam logic [7:0] KP_ENTER = 8'h5A;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   // Odd parity: data bits plus parity bit must hold an odd number of ones
   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_keyboard_rx_fifo.sv
// ps2_key_fifo
//   Show-ahead event FIFO. rd_data always shows the head entry; push and pop
//   may happen in the same cycle, including when full (pop makes room).
//   Ports: ck/reset (async, active high), push/wr_data, pop, rd_data,
//   full, empty. DEPTH must be a power of two so pointers wrap naturally.
module ps2_key_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             ck,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             pop_ok, push_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge ck) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//   PS/2 keyboard receiver: synchronises and filters PS2C, deserialises
//   start/8 data/odd parity/stop frames on filtered clock falls, folds the
//   0xF0 break prefix into per-key events and queues them in ps2_key_fifo.
//   Optional macro PS2_EXTENDED_EN: 0xE0 becomes an extended-key prefix
//   (10-bit entries); otherwise 0xE0 is an ordinary code and key_extended=0.
//   Ports: ck, reset (async, active high), PS2C/PS2D (raw), rd_en (pop),
//   key_code_out/key_released/key_extended (head entry, 0 when empty),
//   key_valid, overflow (sticky), parity_err/framing_err (1-cycle pulses).
module ps2_keyboard_rx
   import ps2_keyboard_rx_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       ck,
   input  logic       reset,
   input  logic       PS2C,
   input  logic       PS2D,
   input  logic       rd_en,
   output logic [7:0] key_code_out,
   output logic       key_released,
   output logic       key_extended,
   output logic       key_valid,
   output logic       overflow,
   output logic       parity_err,
   output logic       framing_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_EXTENDED_EN
   localparam int EW = 10;
`else
   localparam int EW = 9;
`endif

   logic [1:0]    c_sync, d_sync;
   logic          filt_clk;
   logic [FW-1:0] fcnt;
   logic          fall_q, fall_d;

   ps2_state_t    state;
   logic [7:0]    shreg;
   logic [2:0]    bitcnt;
   logic          par_bit;
   logic [TW-1:0] tcnt;
   logic          byte_rdy;
   logic [7:0]    byte_q;
   logic          break_pend;
`ifdef PS2_EXTENDED_EN
   logic          ext_pend;
`endif

   logic          push, fifo_full, fifo_empty, drop;
   logic [EW-1:0] wr_entry, head;

   // Synchronisers and stability filter. A level change on the synchronised
   // clock is accepted only after FILTER_LEN consecutive differing cycles;
   // the fall and the data sampled with it are registered for the FSM.
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         c_sync   <= 2'b11;
         d_sync   <= 2'b11;
         filt_clk <= 1'b1;
         fcnt     <= '0;
         fall_q   <= 1'b0;
         fall_d   <= 1'b1;
      end else begin
         c_sync <= {c_sync[0], PS2C};
         d_sync <= {d_sync[0], PS2D};
         fall_q <= 1'b0;
         if (c_sync[1] == filt_clk) begin
            fcnt <= '0;
         end else if (fcnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= c_sync[1];
            fcnt     <= '0;
            fall_q   <= filt_clk;   // filt_clk=1 here means a 1->0 change
            fall_d   <= d_sync[1];
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   // Frame FSM plus prefix decoder. The decoder acts one cycle after the
   // stop bit, on the registered byte_rdy.
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         shreg       <= '0;
         bitcnt      <= '0;
         par_bit     <= 1'b0;
         tcnt        <= '0;
         byte_rdy    <= 1'b0;
         byte_q      <= '0;
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         break_pend  <= 1'b0;
`ifdef PS2_EXTENDED_EN
         ext_pend    <= 1'b0;
`endif
      end else begin
         byte_rdy    <= 1'b0;
         parity_err  <= 1'b0;
         framing_err <= 1'b0;

         if (byte_rdy) begin
            if (byte_q == KP_KEY_RELEASED) begin
               break_pend <= 1'b1;
`ifdef PS2_EXTENDED_EN
            end else if (byte_q == KP_EXTENDED) begin
               ext_pend <= 1'b1;
`endif
            end else begin
               break_pend <= 1'b0;
`ifdef PS2_EXTENDED_EN
               ext_pend   <= 1'b0;
`endif
            end
         end

         // Abandon a stalled frame silently
         if (state != ST_IDLE && !fall_q) begin
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state <= ST_IDLE;
               tcnt  <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end

         if (fall_q) begin
            tcnt <= '0;
            case (state)
               ST_IDLE: begin
                  if (!fall_d) begin
                     state  <= ST_DATA;
                     bitcnt <= '0;
                  end
               end
               ST_DATA: begin
                  shreg  <= {fall_d, shreg[7:1]};   // LSB arrives first
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin
                  par_bit <= fall_d;
                  state   <= ST_STOP;
               end
               ST_STOP: begin
                  state <= ST_IDLE;
                  // Framing takes priority when both checks fail
                  if (!fall_d || !odd_parity_ok(shreg, par_bit)) begin
                     framing_err <= ~fall_d;
                     parity_err  <= fall_d;
                     break_pend  <= 1'b0;
`ifdef PS2_EXTENDED_EN
                     ext_pend    <= 1'b0;
`endif
                  end else begin
                     byte_rdy <= 1'b1;
                     byte_q   <= shreg;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef PS2_EXTENDED_EN
   assign push     = byte_rdy && byte_q != KP_KEY_RELEASED && byte_q != KP_EXTENDED;
   assign wr_entry = {ext_pend, break_pend, byte_q};
`else
   assign push     = byte_rdy && byte_q != KP_KEY_RELEASED;
   assign wr_entry = {break_pend, byte_q};
`endif

   // A full FIFO still accepts the push when the same cycle pops
   assign drop = push & fifo_full & ~(rd_en & ~fifo_empty);

   ps2_key_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .ck      (ck),
      .reset   (reset),
      .push    (push),
      .wr_data (wr_entry),
      .pop     (rd_en),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge ck or posedge reset) begin
      if (reset)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
   end

   // Head outputs read 0 when empty so stale memory never leaks out
   assign key_valid    = ~fifo_empty;
   assign key_code_out = key_valid ? head[7:0] : 8'h00;
   assign key_released = key_valid & head[8];
`ifdef PS2_EXTENDED_EN
   assign key_extended = key_valid & head[9];
`else
   assign key_extended = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;
   localparam int DEPTH = 4;
   localparam int FL    = 4;
   localparam int TMO   = 400;
   localparam int HALF  = 10;
`ifdef PS2_EXTENDED_EN
   localparam bit EXT_EN = 1'b1;
`else
   localparam bit EXT_EN = 1'b0;
`endif

   logic       ck = 1'b0, reset = 1'b1, PS2C = 1'b1, PS2D = 1'b1, rd_en = 1'b0;
   logic [7:0] key_code_out;
   logic       key_released, key_extended, key_valid, overflow, parity_err, framing_err;

   ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
      .ck(ck), .reset(reset), .PS2C(PS2C), .PS2D(PS2D), .rd_en(rd_en),
      .key_code_out(key_code_out), .key_released(key_released),
      .key_extended(key_extended), .key_valid(key_valid), .overflow(overflow),
      .parity_err(parity_err), .framing_err(framing_err));

   always #5 ck = ~ck;

   typedef struct packed {logic [7:0] code; logic rel; logic ext;} ev_t;

   // Reference model: expected event queue and prefix state
   ev_t exp_q[$];
   bit  m_brk, m_ext, m_ovf;
   int  n_vec = 0, n_err = 0;
   int  pe_cnt = 0, fe_cnt = 0;

   // Counts high cycles; a proper one-cycle pulse adds exactly one
   always @(negedge ck) begin
      if (parity_err)  pe_cnt++;
      if (framing_err) fe_cnt++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      exp_q.delete();
      m_brk = 0; m_ext = 0; m_ovf = 0;
   endtask

   task automatic model_frame(input logic [7:0] d, input bit bp, input bit bs);
      if (bp || bs) begin
         m_brk = 0; m_ext = 0;
      end else if (d == 8'hF0) begin
         m_brk = 1;
      end else if (EXT_EN && d == 8'hE0) begin
         m_ext = 1;
      end else begin
         if (exp_q.size() < DEPTH) exp_q.push_back({d, m_brk, m_ext});
         else m_ovf = 1;
         m_brk = 0; m_ext = 0;
      end
   endtask

   // Bits 0..9 plus the stop-bit clock fall; returns just after that fall
   task automatic send_head(input logic [7:0] d, input bit bp, input bit bs);
      logic [10:0] fr;
      fr = {~bs, (~^d) ^ bp, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         PS2D = fr[i];
         repeat (HALF) @(posedge ck); #1 PS2C = 1'b0;
         repeat (HALF) @(posedge ck); #1 PS2C = 1'b1;
      end
      PS2D = fr[10];
      repeat (HALF) @(posedge ck); #1 PS2C = 1'b0;
   endtask

   task automatic send_tail(input logic [7:0] d, input bit bp, input bit bs);
      repeat (HALF) @(posedge ck); #1 PS2C = 1'b1; PS2D = 1'b1;
      repeat (2*HALF) @(posedge ck); #1;
      model_frame(d, bp, bs);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bp = 0, input bit bs = 0);
      send_head(d, bp, bs);
      send_tail(d, bp, bs);
   endtask

   // Start bit plus three data bits, then stop clocking
   task automatic send_partial();
      logic [3:0] p;
      p = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         PS2D = p[i];
         repeat (HALF) @(posedge ck); #1 PS2C = 1'b0;
         repeat (HALF) @(posedge ck); #1 PS2C = 1'b1;
      end
      PS2D = 1'b1;
   endtask

   task automatic do_pop();
      @(negedge ck); rd_en = 1'b1;
      @(posedge ck); #1 rd_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge ck);
      @(negedge ck); n_vec++;
      if ({key_code_out, key_released, key_extended, key_valid, overflow, parity_err, framing_err} !== 14'h0) begin
         n_err++; $display("FAIL reset_hold: outputs=%h want 0",
            {key_code_out, key_released, key_extended, key_valid, overflow, parity_err, framing_err});
      end
      reset = 1'b0;
      repeat (5) @(posedge ck);
      @(negedge ck); n_vec++;
      if ({key_code_out, key_released, key_extended, key_valid, overflow, parity_err, framing_err} !== 14'h0) begin
         n_err++; $display("FAIL reset_release: outputs=%h want 0",
            {key_code_out, key_released, key_extended, key_valid, overflow, parity_err, framing_err});
      end
      model_reset();
   endtask

   task automatic test_glitch_make();
      ev_t e;
      @(posedge ck); #1 PS2C = 1'b0;
      repeat (2) @(posedge ck); #1 PS2C = 1'b1;
      repeat (30) @(posedge ck);
      @(negedge ck); n_vec++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL glitch: key_valid=%b want 0", key_valid); end
      send_head(8'h69, 0, 0);
      // fall detected 2+FL cycles after the raw edge; valid two cycles later
      repeat (FL+3) @(posedge ck);
      @(negedge ck); n_vec++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL make_early: key_valid=%b want 0", key_valid); end
      @(posedge ck); @(negedge ck); n_vec++;
      if (key_valid !== 1'b1) begin n_err++; $display("FAIL make_latency: key_valid=%b want 1", key_valid); end
      send_tail(8'h69, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge ck); n_vec++;
         if ({key_valid, key_code_out, key_released, key_extended} !== {1'b1, e}) begin
            n_err++; $display("FAIL make_entry: got v=%b %h rel=%b ext=%b want %h rel=%b ext=%b",
               key_valid, key_code_out, key_released, key_extended, e.code, e.rel, e.ext);
         end
         do_pop();
      end
      @(negedge ck); n_vec++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL make_empty: key_valid=%b want 0", key_valid); end
   endtask

   task automatic test_break();
      ev_t e;
      send_frame(8'hF0);
      @(negedge ck); n_vec++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL break_prefix_push: key_valid=%b want 0", key_valid); end
      send_frame(8'h69);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge ck); n_vec++;
         if ({key_valid, key_code_out, key_released, key_extended} !== {1'b1, e}) begin
            n_err++; $display("FAIL break_entry: got v=%b %h rel=%b ext=%b want %h rel=%b ext=%b",
               key_valid, key_code_out, key_released, key_extended, e.code, e.rel, e.ext);
         end
         do_pop();
      end
      @(negedge ck); n_vec++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL break_empty: key_valid=%b want 0", key_valid); end
   endtask

   task automatic test_errors();
      ev_t e;
      int  pe0, fe0;
      pe0 = pe_cnt; fe0 = fe_cnt;
      send_head(8'h72, 1, 0);
      repeat (FL+2) @(posedge ck); @(negedge ck); n_vec++;
      if (parity_err !== 1'b0) begin n_err++; $display("FAIL parity_early: parity_err=%b want 0", parity_err); end
      @(posedge ck); @(negedge ck); n_vec++;
      if (parity_err !== 1'b1) begin n_err++; $display("FAIL parity_pulse: parity_err=%b want 1", parity_err); end
      @(posedge ck); @(negedge ck); n_vec++;
      if (parity_err !== 1'b0) begin n_err++; $display("FAIL parity_width: parity_err=%b want 0", parity_err); end
      send_tail(8'h72, 1, 0);
      n_vec++;
      if (pe_cnt - pe0 !== 1 || fe_cnt - fe0 !== 0 || key_valid !== 1'b0) begin
         n_err++; $display("FAIL parity_frame: pe=%0d fe=%0d v=%b want 1 0 0", pe_cnt - pe0, fe_cnt - fe0, key_valid);
      end
      send_frame(8'hF0);
      pe0 = pe_cnt; fe0 = fe_cnt;
      send_frame(8'h72, 0, 1);
      n_vec++;
      if (pe_cnt - pe0 !== 0 || fe_cnt - fe0 !== 1 || key_valid !== 1'b0) begin
         n_err++; $display("FAIL framing_frame: pe=%0d fe=%0d v=%b want 0 1 0", pe_cnt - pe0, fe_cnt - fe0, key_valid);
      end
      pe0 = pe_cnt; fe0 = fe_cnt;
      send_frame(8'h72, 1, 1);
      n_vec++;
      if (pe_cnt - pe0 !== 0 || fe_cnt - fe0 !== 1 || key_valid !== 1'b0) begin
         n_err++; $display("FAIL both_bad: pe=%0d fe=%0d v=%b want 0 1 0", pe_cnt - pe0, fe_cnt - fe0, key_valid);
      end
      send_frame(8'h72);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge ck); n_vec++;
         if ({key_valid, key_code_out, key_released, key_extended} !== {1'b1, e}) begin
            n_err++; $display("FAIL err_recover_entry: got v=%b %h rel=%b ext=%b want %h rel=%b ext=%b",
               key_valid, key_code_out, key_released, key_extended, e.code, e.rel, e.ext);
         end
         do_pop();
      end
      @(negedge ck); n_vec++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL err_empty: key_valid=%b want 0", key_valid); end
   endtask

   task automatic test_overflow();
      ev_t e;
      logic [7:0] codes [5];
      codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
      for (int i = 0; i < 4; i++) send_frame(codes[i]);
      @(negedge ck); n_vec++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_full: overflow=%b want 0", overflow); end
      send_frame(codes[4]);
      @(negedge ck); n_vec++;
      if (overflow !== m_ovf) begin n_err++; $display("FAIL ovf_set: overflow=%b want %b", overflow, m_ovf); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge ck); n_vec++;
         if ({key_valid, key_code_out, key_released, key_extended} !== {1'b1, e}) begin
            n_err++; $display("FAIL ovf_entry: got v=%b %h rel=%b ext=%b want %h rel=%b ext=%b",
               key_valid, key_code_out, key_released, key_extended, e.code, e.rel, e.ext);
         end
         do_pop();
      end
      @(negedge ck); n_vec++;
      if (key_valid !== 1'b0 || overflow !== 1'b1) begin
         n_err++; $display("FAIL ovf_drained: v=%b ovf=%b want 0 1", key_valid, overflow);
      end
      @(posedge ck); #1 reset = 1'b1;
      @(posedge ck); #1 reset = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) send_frame(codes[i]);
      // Pop lands in the same cycle as the fifth push
      send_head(codes[4], 0, 0);
      repeat (FL+3) @(posedge ck); #1 rd_en = 1'b1;
      @(posedge ck); #1 rd_en = 1'b0;
      void'(exp_q.pop_front());
      send_tail(codes[4], 0, 0);
      @(negedge ck); n_vec++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_simul: overflow=%b want 0", overflow); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge ck); n_vec++;
         if ({key_valid, key_code_out, key_released, key_extended} !== {1'b1, e}) begin
            n_err++; $display("FAIL simul_entry: got v=%b %h rel=%b ext=%b want %h rel=%b ext=%b",
               key_valid, key_code_out, key_released, key_extended, e.code, e.rel, e.ext);
         end
         do_pop();
      end
      @(negedge ck); n_vec++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty: key_valid=%b want 0", key_valid); end
   endtask

   task automatic test_timeout();
      ev_t e;
      int  pe0, fe0;
      pe0 = pe_cnt; fe0 = fe_cnt;
      send_partial();
      repeat (TMO + 10) @(posedge ck); #1;
      send_frame(8'h7A);
      n_vec++;
      if (pe_cnt - pe0 !== 0 || fe_cnt - fe0 !== 0) begin
         n_err++; $display("FAIL timeout_noerr: pe=%0d fe=%0d want 0 0", pe_cnt - pe0, fe_cnt - fe0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge ck); n_vec++;
         if ({key_valid, key_code_out, key_released, key_extended} !== {1'b1, e}) begin
            n_err++; $display("FAIL timeout_entry: got v=%b %h rel=%b ext=%b want %h rel=%b ext=%b",
               key_valid, key_code_out, key_released, key_extended, e.code, e.rel, e.ext);
         end
         do_pop();
      end
      @(negedge ck); n_vec++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL timeout_empty: key_valid=%b want 0", key_valid); end
   endtask

   task automatic test_reset_midframe();
      ev_t e;
      send_frame(8'h7A);
      send_frame(8'hF0);
      send_partial();
      @(posedge ck); #1 reset = 1'b1;
      repeat (3) @(posedge ck);
      @(negedge ck); n_vec++;
      if ({key_code_out, key_released, key_extended, key_valid, overflow, parity_err, framing_err} !== 14'h0) begin
         n_err++; $display("FAIL midframe_reset: outputs=%h want 0",
            {key_code_out, key_released, key_extended, key_valid, overflow, parity_err, framing_err});
      end
      reset = 1'b0;
      model_reset();
      repeat (4) @(posedge ck); #1;
      send_frame(8'h69);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge ck); n_vec++;
         if ({key_valid, key_code_out, key_released, key_extended} !== {1'b1, e}) begin
            n_err++; $display("FAIL post_reset_entry: got v=%b %h rel=%b ext=%b want %h rel=%b ext=%b",
               key_valid, key_code_out, key_released, key_extended, e.code, e.rel, e.ext);
         end
         do_pop();
      end
      @(negedge ck); n_vec++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_empty: key_valid=%b want 0", key_valid); end
   endtask

   task automatic test_extended();
      ev_t e;
      send_frame(8'hE0);
      send_frame(8'hF0);
      send_frame(8'h75);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge ck); n_vec++;
         if ({key_valid, key_code_out, key_released, key_extended} !== {1'b1, e}) begin
            n_err++; $display("FAIL ext_entry: got v=%b %h rel=%b ext=%b want %h rel=%b ext=%b",
               key_valid, key_code_out, key_released, key_extended, e.code, e.rel, e.ext);
         end
         do_pop();
      end
      @(negedge ck); n_vec++;
      if (key_valid !== 1'b0) begin n_err++; $display("FAIL ext_empty: key_valid=%b want 0", key_valid); end
   endtask

   task automatic test_random();
      ev_t e;
      int  pe0, fe0, r;
      logic [7:0] code;
      bit bp, bs;
      for (int it = 0; it < 16; it++) begin
         r    = $urandom_range(0, 5);
         code = 8'($urandom_range(0, 255));
         if (r == 0) code = 8'hF0;
         if (r == 1) code = 8'hE0;
         bp = ($urandom_range(0, 6) == 0);
         bs = ($urandom_range(0, 6) == 0);
         pe0 = pe_cnt; fe0 = fe_cnt;
         send_frame(code, bp, bs);
         n_vec++;
         if (pe_cnt - pe0 !== int'(bp && !bs) || fe_cnt - fe0 !== int'(bs)) begin
            n_err++; $display("FAIL rand_err code=%h bp=%b bs=%b: pe=%0d fe=%0d", code, bp, bs, pe_cnt - pe0, fe_cnt - fe0);
         end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge ck); n_vec++;
            if ({key_valid, key_code_out, key_released, key_extended} !== {1'b1, e}) begin
               n_err++; $display("FAIL rand_entry: got v=%b %h rel=%b ext=%b want %h rel=%b ext=%b",
                  key_valid, key_code_out, key_released, key_extended, e.code, e.rel, e.ext);
            end
            do_pop();
         end
         @(negedge ck); n_vec++;
         if (key_valid !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL rand_empty: v=%b ovf=%b want 0 0", key_valid, overflow);
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch_make();
      test_break();
      test_errors();
      test_overflow();
      test_timeout();
      test_reset_midframe();
      test_extended();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
